// File: rtl/fifo_to_com.sv
// fifo_to_com: drains an upstream FIFO byte-by-byte onto a UART 8N1 line while folding each byte into a CRC-8.
// Define FIFO_TO_COM_CRC_APPEND_EN to send the CRC as a trailer frame at the end of each burst.
module fifo_to_com #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data_in,
    output logic       fifo_re,
    output logic       tx,
    output logic       busy,
    output logic       isFinish,
    output logic [7:0] CRC
);
    typedef enum logic [2:0] {
        IDLE, READ, WAIT, CRCCALC, START, DATA, STOP
`ifdef FIFO_TO_COM_CRC_APPEND_EN
        , CRCSEND
`endif
    } state_t;
    state_t      state_q;
    logic [7:0]  shift_q, crc_q;
    logic [2:0]  idx_q;
    logic [15:0] cnt_q;
    logic        fifo_re_q, tx_q, busy_q, fin_q;
`ifdef FIFO_TO_COM_CRC_APPEND_EN
    logic        trailer_q;
`endif
    logic        last, fb;
    assign last = cnt_q == 16'(CLKS_PER_BIT - 1);
    assign fb = crc_q[7] ^ shift_q[idx_q];
    assign fifo_re = fifo_re_q;
    assign tx = tx_q;
    assign busy = busy_q;
    assign isFinish = fin_q;
    assign CRC = crc_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= 8'h00;
            crc_q     <= 8'h00;
            idx_q     <= 3'd0;
            cnt_q     <= 16'd0;
            fifo_re_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
`ifdef FIFO_TO_COM_CRC_APPEND_EN
            trailer_q <= 1'b0;
`endif
        end else begin
            fifo_re_q <= 1'b0;
            fin_q     <= 1'b0;
            // The bit-period counter wraps to zero on every bit boundary.
            if (state_q inside {START, DATA, STOP}) cnt_q <= last ? 16'd0 : cnt_q + 16'd1;
            case (state_q)
                IDLE: if (enable && !fifo_empty) begin
                    state_q   <= READ;
                    fifo_re_q <= 1'b1;
                    busy_q    <= 1'b1;
                end
                READ: state_q <= WAIT;
                WAIT: begin
                    shift_q <= fifo_data_in;
                    idx_q   <= 3'd7;
                    state_q <= CRCCALC;
                end
                CRCCALC: begin
                    crc_q <= {crc_q[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
                    idx_q <= idx_q - 3'd1;
                    if (idx_q == 3'd0) begin
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: if (last) begin
                    state_q <= DATA;
                    tx_q    <= shift_q[0];
                    idx_q   <= 3'd0;
                end
                DATA: if (last) begin
                    if (idx_q == 3'd7) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                        tx_q  <= shift_q[idx_q + 3'd1];
                    end
                end
                STOP: if (last) begin
`ifdef FIFO_TO_COM_CRC_APPEND_EN
                    if (trailer_q) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        fin_q     <= 1'b1;
                        crc_q     <= 8'h00;
                        trailer_q <= 1'b0;
                    end else if (fifo_empty) begin
                        state_q <= CRCSEND;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
`else
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    fin_q   <= fifo_empty;
`endif
                end
`ifdef FIFO_TO_COM_CRC_APPEND_EN
                CRCSEND: begin
                    shift_q   <= crc_q;
                    trailer_q <= 1'b1;
                    state_q   <= START;
                    tx_q      <= 1'b0;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fifo_to_com.md
FIFO_TO_COM -- requirements
Module: fifo_to_com

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, clk cycles per UART bit (9600 baud at 50 MHz); legal range 8..65535.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  permits starting a new FIFO read.
REQ-005 SHALL have port fifo_empty  input  1  upstream FIFO holds no byte.
REQ-006 SHALL have port fifo_data_in  input  8  FIFO read data, valid one cycle after fifo_re.
REQ-007 SHALL have port fifo_re  output  1  FIFO read strobe, one-cycle pulse per byte.
REQ-008 SHALL have port tx  output  1  UART 8N1 serial line, idle high.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port isFinish  output  1  one-cycle pulse at end of a transfer burst.
REQ-011 SHALL have port CRC  output  8  running CRC-8 of transmitted data bytes.

Function
REQ-012 SHALL implement states IDLE, READ, WAIT, CRCCALC, START, DATA, STOP (plus CRCSEND when REQ-029 applies); all outputs registered.
REQ-013 IDLE: on enable=1 and fifo_empty=0 at edge E0, SHALL go READ with fifo_re=1 after E0; otherwise stay, fifo_re=0.
REQ-014 READ: at E1 SHALL drop fifo_re and go WAIT; fifo_re high exactly one cycle per byte.
REQ-015 WAIT: at E2 SHALL capture fifo_data_in into shift register, bit index 7, go CRCCALC.
REQ-016 CRCCALC: edges E3..E10 SHALL fold captured bits MSB first into CRC: fb=CRC[7]^bit, CRC=CRC<<1, XOR 0x07 if fb (poly x^8+x^2+x+1, init 0x00); at E10 go START, tx=0.
REQ-017 tx SHALL first be low 10 cycles after fifo_re is first high.
REQ-018 START, each DATA bit and STOP SHALL hold tx exactly CLKS_PER_BIT cycles via a bit-period counter reset on every bit boundary.
REQ-019 DATA SHALL send bits 0..7 LSB first; STOP drives tx=1.
REQ-020 At end of STOP SHALL return to IDLE; next byte may start at the following edge (back-to-back frames, no extra idle bit).
REQ-021 isFinish SHALL pulse one cycle at end of the last frame of a burst, i.e. STOP completes with fifo_empty=1.
REQ-022 enable deassert mid-frame SHALL NOT abort; current frame completes, no new read starts.
REQ-023 fifo_empty rising during WAIT..STOP SHALL NOT affect the byte in flight.
REQ-024 CRC SHALL accumulate across bytes and clear only on reset (or per REQ-029).
REQ-025 tx SHALL never glitch: changes only at bit boundaries or on reset.

Reset
REQ-026 On reset=1 at any edge, including mid-frame, SHALL force IDLE, tx=1, fifo_re=0, busy=0, isFinish=0, CRC=0x00, counters 0.
REQ-027 A byte read but not fully sent when reset hits SHALL be discarded, not re-read.

Configuration
REQ-028 Macro FIFO_TO_COM_CRC_APPEND_EN SHALL select CRC trailer behaviour.
REQ-029 Defined: when STOP of a data frame completes with fifo_empty=1, SHALL enter CRCSEND and send CRC as an extra 8N1 frame (LSB first, no CRC update), then set CRC=0x00; isFinish pulses after the trailer's STOP instead of REQ-021's point.
REQ-030 Undefined: no trailer frame, no CRCSEND state, CRC never auto-clears, isFinish per REQ-021.

Verification (CLKS_PER_BIT=8)
REQ-031 FIFO={0xA5}, enable=1 -> fifo_re 1 cycle; tx low 10 cycles later; bits 1,0,1,0,0,1,0,1 each 8 cycles; stop high; CRC=0x72; isFinish one pulse.
REQ-032 FIFO={0x01,0x02} -> two back-to-back frames, fifo_re exactly twice; CRC=0x07 after first, 0x1B after second.
REQ-033 FIFO non-empty, enable=0 for 100 cycles -> fifo_re=0, tx=1, busy=0 throughout.
REQ-034 Reset asserted at 3rd DATA bit -> next cycle tx=1, busy=0, CRC=0x00; no further fifo_re until enable and non-empty.
REQ-035 Macro defined, FIFO={0x01,0x02} -> third frame carries 0x1B (bits 1,1,0,1,1,0,0,0); isFinish after its STOP; CRC=0x00 after.
REQ-036 fifo_empty=1, enable=1 for 200 cycles -> no fifo_re, tx=1, isFinish=0.
